// File: rtl/block_data_memory.sv
// Multi-cycle block data memory for data-cache line fills and write-backs.
// The request is latched on acceptance, the access happens after LATENCY edges, then a DONE cycle follows.
module block_data_memory #(
  parameter int BLOCK_BYTES = 16,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 28,
  parameter int LATENCY     = 5
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_WIDTH-1:0]    ADDRESS,
  input  logic [8*BLOCK_BYTES-1:0] WRITEDATA,
  input  logic [BLOCK_BYTES-1:0]   BYTEEN,
  output logic [8*BLOCK_BYTES-1:0] READDATA,
  output logic                     BUSYWAIT,
  output logic                     ERROR
);

  localparam int DW    = 8 * BLOCK_BYTES;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_write_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DW-1:0]          wdata_q;
  logic [BLOCK_BYTES-1:0] be_q;
  logic [DW-1:0]          rdata_q;
  logic                   error_q;
  logic [DW-1:0]          mem_q [DEPTH];

  logic req_one;
  logic accept;
  logic complete;

  assign req_one  = READ ^ WRITE;
  assign accept   = (state_q == ST_IDLE) && req_one;
  assign complete = (state_q == ST_BUSY) && (cnt_q == '0);

  // Upper address bits alias onto the same block.
  if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[ADDR_WIDTH-1:IDX_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_one) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= (state_q == ST_IDLE) && READ && WRITE;
      if (accept) begin
        op_write_q <= WRITE;
        idx_q      <= ADDRESS[IDX_W-1:0];
        wdata_q    <= WRITEDATA;
        be_q       <= BYTEEN;
      end
      if (complete && !op_write_q) rdata_q <= mem_q[idx_q];
    end
  end

  // Reset clears the whole array, so an in-flight write is simply lost.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (complete && op_write_q) begin
      for (int b = 0; b < BLOCK_BYTES; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign READDATA = rdata_q;
  assign ERROR    = error_q;
  assign BUSYWAIT = (state_q == ST_BUSY) || accept;

endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory: a LATENCY=5 instance and a LATENCY=1 instance.
// Expected read blocks come from a byte-enable memory model through a scoreboard queue.
module tb_block_data_memory;

  logic         CLOCK;
  logic         RESET;
  logic         rd0, wr0, rd1, wr1;
  logic [27:0]  addr0, addr1;
  logic [127:0] wd0, wd1;
  logic [15:0]  be0, be1;
  logic [127:0] rdata0, rdata1;
  logic         bw0, bw1, err0, err1;

  int checks = 0;
  int errors = 0;

  logic [127:0] model0 [256];
  logic [127:0] model1 [256];
  logic [127:0] exp_q [$];

  block_data_memory dut (
    .CLOCK(CLOCK), .RESET(RESET), .READ(rd0), .WRITE(wr0), .ADDRESS(addr0),
    .WRITEDATA(wd0), .BYTEEN(be0), .READDATA(rdata0), .BUSYWAIT(bw0), .ERROR(err0)
  );

  block_data_memory #(.LATENCY(1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .READ(rd1), .WRITE(wr1), .ADDRESS(addr1),
    .WRITEDATA(wd1), .BYTEEN(be1), .READDATA(rdata1), .BUSYWAIT(bw1), .ERROR(err1)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] be);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      model0[i] = '0;
      model1[i] = '0;
    end
  endtask

  // One access on instance sel; optionally scrambles inputs while the access is in flight.
  task automatic do_access(input bit sel, input bit is_write, input logic [27:0] addr,
                           input logic [127:0] data, input logic [15:0] be,
                           input bit scramble, input string name);
    int busy_cnt;
    int exp_busy;
    bit done;
    logic [127:0] old_rd;
    logic [127:0] rd_now;
    logic [127:0] exp_rd;
    logic         bw_now;
    exp_busy = sel ? 2 : 6;
    busy_cnt = 0;
    done     = 1'b0;
    @(posedge CLOCK); #1;
    if (sel) begin
      rd1 = !is_write; wr1 = is_write; addr1 = addr; wd1 = data; be1 = be;
      old_rd = rdata1;
      if (is_write) model1[addr[7:0]] = merge(model1[addr[7:0]], data, be);
      else exp_q.push_back(model1[addr[7:0]]);
    end else begin
      rd0 = !is_write; wr0 = is_write; addr0 = addr; wd0 = data; be0 = be;
      old_rd = rdata0;
      if (is_write) model0[addr[7:0]] = merge(model0[addr[7:0]], data, be);
      else exp_q.push_back(model0[addr[7:0]]);
    end
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge CLOCK);
      bw_now = sel ? bw1 : bw0;
      rd_now = sel ? rdata1 : rdata0;
      if (bw_now === 1'b1) begin
        busy_cnt++;
        checks++;
        if (rd_now !== old_rd) begin
          errors++;
          $display("FAIL %s readdata_while_busy cycle %0d: got %h want %h", name, busy_cnt, rd_now, old_rd);
        end
        if (scramble && busy_cnt >= 2) begin
          addr0 = 28'($urandom);
          wd0   = {$urandom, $urandom, $urandom, $urandom};
          be0   = 16'($urandom);
        end
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: BUSYWAIT never fell within 20 cycles", name);
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    if (!is_write) begin
      exp_rd = exp_q.pop_front();
      checks++;
      if (rd_now !== exp_rd) begin
        errors++;
        $display("FAIL %s readdata: got %h want %h", name, rd_now, exp_rd);
      end
    end
    if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
    else     begin rd0 = 1'b0; wr0 = 1'b0; end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    checks++;
    if ({rdata0, bw0, err0, rdata1, bw1, err1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd0=%h bw0=%b err0=%b bw1=%b err1=%b want zeros",
               rdata0, bw0, err0, bw1, err1);
    end
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    clear_models();
    do_access(1'b0, 1'b0, 28'h3A, '0, '0, 1'b0, "reset_read_3a");
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 28'h3A, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF, 1'b0, "write_3a");
    do_access(1'b0, 1'b0, 28'h3A, '0, '0, 1'b0, "read_3a");
  endtask

  task automatic test_byte_enables();
    do_access(1'b0, 1'b1, 28'h3A, {128{1'b1}}, 16'h000F, 1'b0, "be_write_3a");
    do_access(1'b0, 1'b0, 28'h3A, '0, '0, 1'b0, "be_read_3a");
    checks++;
    if (model0[8'h3A] !== 128'h00112233445566778899AABBFFFFFFFF) begin
      errors++;
      $display("FAIL be_model: got %h want %h", model0[8'h3A], 128'h00112233445566778899AABBFFFFFFFF);
    end
  endtask

  task automatic test_latency1();
    do_access(1'b1, 1'b1, 28'h07, 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF, 16'hFFFF, 1'b0, "l1_write_07");
    do_access(1'b1, 1'b0, 28'h07, '0, '0, 1'b0, "l1_read_07");
    do_access(1'b1, 1'b1, 28'h07, 128'h0, 16'h00F0, 1'b0, "l1_be_write_07");
    do_access(1'b1, 1'b0, 28'h07, '0, '0, 1'b0, "l1_be_read_07");
  endtask

  task automatic test_input_stability();
    do_access(1'b0, 1'b1, 28'h20, 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0, 16'hF0F0, 1'b1, "stab_write_20");
    do_access(1'b0, 1'b0, 28'h20, '0, '0, 1'b1, "stab_read_20");
    do_access(1'b0, 1'b0, 28'h3A, '0, '0, 1'b1, "stab_read_3a");
  endtask

  task automatic test_illegal();
    @(posedge CLOCK); #1;
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 28'h3A; wd0 = '0; be0 = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK);
      checks++;
      if (bw0 !== 1'b0) begin
        errors++;
        $display("FAIL illegal_busywait cycle %0d: got %b want 0", k, bw0);
      end
      checks++;
      if (err0 !== ((k >= 1 && k <= 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL illegal_error cycle %0d: got %b want %b", k, err0, (k >= 1 && k <= 3));
      end
      @(posedge CLOCK); #1;
      if (k == 2) begin rd0 = 1'b0; wr0 = 1'b0; end
    end
    do_access(1'b0, 1'b0, 28'h3A, '0, '0, 1'b0, "illegal_read_3a");
  endtask

  task automatic test_aliasing();
    do_access(1'b0, 1'b1, 28'h13A, 128'h13A013A0_FEEDFACE_0BADC0DE_77665544, 16'hFFFF, 1'b0, "alias_write_13a");
    do_access(1'b0, 1'b0, 28'h03A, '0, '0, 1'b0, "alias_read_03a");
  endtask

  task automatic test_reset_mid_write();
    @(posedge CLOCK); #1;
    wr0 = 1'b1; rd0 = 1'b0; addr0 = 28'h10; wd0 = {4{32'h1357_9BDF}}; be0 = 16'hFFFF;
    repeat (4) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    wr0 = 1'b0;
    #1;
    checks++;
    if ({rdata0, bw0, err0} !== '0) begin
      errors++;
      $display("FAIL midwrite_reset_outputs: got rd=%h bw=%b err=%b want zeros", rdata0, bw0, err0);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    clear_models();
    #1;
    checks++;
    if (bw0 !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_busywait_after_reset: got %b want 0", bw0);
    end
    do_access(1'b0, 1'b0, 28'h10, '0, '0, 1'b0, "midwrite_read_10");
    do_access(1'b0, 1'b0, 28'h3A, '0, '0, 1'b0, "midwrite_read_3a");
  endtask

  initial begin
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0; be0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; be1 = '0;
    clear_models();
    test_reset();
    test_write_read();
    test_byte_enables();
    test_latency1();
    test_input_stability();
    test_illegal();
    test_aliasing();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_data_memory.md
# block_data_memory

Parametrised, multi-cycle, block-wide data memory that serves cache line fills and write-backs for the RV32IM pipeline's data cache. It is the successor of the fixed 16-byte, 256-line data memory. Block width, depth and access latency are parameters, and writes take per-byte enables. A registered latency counter and a BUSYWAIT handshake with a completion state stop a still-asserted request from re-triggering.

## Interface
- BLOCK_BYTES, 16, bytes per block; power of 2, ≥4
- DEPTH, 256, blocks stored; power of 2, ≥2
- ADDR_WIDTH, 28, block-address width; ≥ log2(DEPTH)
- LATENCY, 5, access latency in clock edges after acceptance; ≥1
- CLOCK  input  1  clock; all state changes on rising edge
- RESET  input  1  reset RESET, asynchronous, active-high
- READ  input  1  block read request; held by requester until BUSYWAIT falls
- WRITE  input  1  block write request; same holding rule
- ADDRESS  input  ADDR_WIDTH  block address; index = ADDRESS[log2(DEPTH)-1:0], upper bits ignored (aliasing)
- WRITEDATA  input  8*BLOCK_BYTES  write block; byte i = bits [8i+7:8i]
- BYTEEN  input  BLOCK_BYTES  write byte enables; bit i gates byte i
- READDATA  output  8*BLOCK_BYTES  registered read block
- BUSYWAIT  output  1  stall to requester
- ERROR  output  1  registered one-cycle pulse on illegal request (READ & WRITE)

## Operation
- FSM states and transitions:
  - IDLE: an edge with READ^WRITE accepts the request. It latches op, index, WRITEDATA and BYTEEN, loads cnt=LATENCY-1 and moves to BUSY.
  - BUSY: at each edge with cnt≠0, cnt decrements. At the edge with cnt==0 the access is performed and the FSM moves to DONE.
  - DONE: requests are ignored. Unconditional move to IDLE at the next edge.
- Read access: READDATA ← MEM[index], full block.
- Write access: MEM[index] byte i ← latched WRITEDATA byte i only where latched BYTEEN[i]=1. Other bytes are unchanged. READDATA is unchanged.
- Inputs changing during BUSY or DONE have no effect; the latched copies are used.
- BUSYWAIT is combinational:
  - 1 in IDLE when READ^WRITE.
  - 1 throughout BUSY.
  - 0 in DONE.
  - 0 in IDLE with no request or with both requests.
- Illegal request: READ&WRITE in IDLE is not accepted. ERROR=1 for the cycle after that edge, BUSYWAIT stays 0, and memory and READDATA are unchanged. A held illegal request pulses ERROR every cycle.
- READDATA holds its value until the next completed read.
- Reset, asynchronous:
  - State → IDLE, cnt=0, READDATA=0, ERROR=0.
  - All MEM blocks → 0.
  - A write in flight is discarded and never committed.
- Only READ^WRITE is sampled in IDLE. Simultaneous new request plus completion is impossible, because DONE separates them.

## Timing
- Let the request first be visible in cycle 0, with acceptance edge E0.
- BUSYWAIT is high from cycle 0 through the cycle ending at edge E_LATENCY, i.e. for LATENCY+1 cycles.
- At E_LATENCY, READDATA is updated or the memory write is committed. BUSYWAIT is 0 in the following cycle (DONE).
- The requester deasserts or changes its request during DONE. The earliest next acceptance is the edge ending the first IDLE cycle, E_LATENCY+2.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- LATENCY=1: acceptance at E0, completion at E1, DONE in cycle 2.
- cnt width is clog2(LATENCY). For LATENCY=1, cnt is constant 0.

## Test plan
- Reset: assert RESET mid-cycle without a clock edge → READDATA=0, BUSYWAIT=0, ERROR=0 immediately. A subsequent read of index 0x3A returns 0.
- Write then read (defaults): WRITE with ADDRESS=0x3A, WRITEDATA=0x00112233445566778899AABBCCDDEEFF, BYTEEN=0xFFFF. BUSYWAIT must be high for exactly 6 cycles, then low for 1.
  - READ of 0x3A returns the same value at E5.
  - READDATA must not change during the write.
- Byte enables: over the block above, write 0xFF…FF with BYTEEN=0x000F → read returns 0x00112233445566778899AABBFFFFFFFF.
- Latency parameter and input stability:
  - LATENCY=1 instance: the read completes at E1 and BUSYWAIT is high for 2 cycles.
  - LATENCY=5: during BUSY, change ADDRESS and WRITEDATA every cycle → the latched values are used.
- Illegal request and aliasing:
  - READ=WRITE=1 for 3 cycles → ERROR high 3 cycles, BUSYWAIT 0, memory unchanged.
  - Write ADDRESS=0x13A with DEPTH=256 → a read of 0x03A returns that data.
- Reset mid-write: assert RESET at E3 of a write to 0x10 → after release, a read of 0x10 returns 0 and BUSYWAIT is 0 immediately after reset.
